// File: rtl/maverik_core.sv
// maverik_core: parametrised accumulator processor with FETCH / EXEC / HALT sequencing.
// Optional MAVERIK_SIGNED_OFFSET_EN: JMP/BRZ offsets become two's-complement (backward branches).
module maverik_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [IMM_W+2:0]  imem_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              zflag,
  output logic              cflag,
  output logic              halted
);

  localparam int INSTR_W = IMM_W + 3;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADDI = 3'b010,
    OP_JMP  = 3'b011,
    OP_SUBI = 3'b100,
    OP_ANDI = 3'b101,
    OP_BRZ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic [INSTR_W-1:0]  ir_reg;
  logic                z_reg;
  logic                c_reg;
  logic                halted_reg;
  logic                req_reg;

  logic [DATA_W-1:0]   acc_next;
  logic [PC_W-1:0]     pc_next;
  logic                z_next;
  logic                c_next;
  logic                halt_next;

  opcode_t             opcode;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_data;
  logic [PC_W-1:0]     offset;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     pc_branch;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  assign opcode = opcode_t'(ir_reg[IMM_W+2:IMM_W]);
  assign imm    = ir_reg[IMM_W-1:0];

  // ALU immediates are always zero-extended.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_imm_data
      if (gi < IMM_W) begin : g_bit
        assign imm_data[gi] = imm[gi];
      end else begin : g_zero
        assign imm_data[gi] = 1'b0;
      end
    end

    // Control-transfer offset: upper bits follow the build-time signedness choice.
    for (gi = 0; gi < PC_W; gi++) begin : g_offset
      if (gi < IMM_W) begin : g_bit
        assign offset[gi] = imm[gi];
      end else begin : g_ext
`ifdef MAVERIK_SIGNED_OFFSET_EN
        assign offset[gi] = imm[IMM_W-1];
`else
        assign offset[gi] = 1'b0;
`endif
      end
    end
  endgenerate

  // pc arithmetic wraps modulo 2^PC_W; branch targets are relative to the branch itself.
  assign pc_inc    = pc_reg + PC_W'(1);
  assign pc_branch = pc_reg + offset;
  assign sum       = {1'b0, acc_reg} + {1'b0, imm_data};
  assign diff      = {1'b0, acc_reg} - {1'b0, imm_data};

  always_comb begin
    acc_next  = acc_reg;
    pc_next   = pc_inc;
    c_next    = c_reg;
    halt_next = 1'b0;
    unique case (opcode)
      OP_NOP:  ;
      OP_LDI:  acc_next = imm_data;
      OP_ADDI: {c_next, acc_next} = sum;
      OP_JMP:  pc_next = pc_branch;
      OP_SUBI: {c_next, acc_next} = diff;
      OP_ANDI: acc_next = acc_reg & imm_data;
      OP_BRZ:  pc_next = z_reg ? pc_branch : pc_inc;
      OP_HALT: begin
        pc_next   = pc_reg;
        halt_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Flag-neutral ops keep z; ALU ops compute it from the freshly produced accumulator.
  always_comb begin
    z_next = z_reg;
    case (opcode)
      OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI: z_next = (acc_next == '0);
      default: z_next = z_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_FETCH;
      pc_reg     <= '0;
      acc_reg    <= '0;
      ir_reg     <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      halted_reg <= 1'b0;
      req_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem_valid) begin
            ir_reg    <= imem_data;
            req_reg   <= 1'b0;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc_reg <= acc_next;
          pc_reg  <= pc_next;
          z_reg   <= z_next;
          c_reg   <= c_next;
          if (halt_next) begin
            halted_reg <= 1'b1;
            req_reg    <= 1'b0;
            state_reg  <= ST_HALT;
          end else begin
            req_reg   <= 1'b1;
            state_reg <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: begin
          req_reg   <= 1'b0;
          state_reg <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;
  assign acc_out   = acc_reg;
  assign pc_out    = pc_reg;
  assign zflag     = z_reg;
  assign cflag     = c_reg;
  assign halted    = halted_reg;

endmodule
